mem_iface: RTL and testbench
============================

Name: mem_iface

Overview:
- Memory interface stage directly downstream of the multicycle control FSM. It consumes MemRead, MemWrite, IorD and IRenable.
- Drives a req/ack memory bus and stalls the control FSM until the access completes.
- Holds the Instruction Register (IR), which feeds OPcode back to control, and the Memory Data Register (MDR), which feeds the CR write-back mux.
- Adds a bus timeout, sticky error flags, and a single-cycle completion window so a held command is never re-issued.

Parameters:
- DATA_W, 16, data, instruction and IR/MDR width
- ADDR_W, 16, memory address width
- TIMEOUT, 15, max cycles waiting for mem_ack before abort (≥1)
- ERR_DATA, 16'hFFFF, value loaded into IR/MDR on timeout

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- MemRead  in  1  read command from control (level, held while Stall=1)
- MemWrite  in  1  write command from control (level, held while Stall=1)
- IorD  in  1  address select: 0 = pc_addr, 1 = alu_addr
- IRenable  in  1  read result goes to IR (1) or MDR (0)
- pc_addr  in  ADDR_W  program counter
- alu_addr  in  ADDR_W  ALU-computed data address
- wdata  in  DATA_W  store data (CR value)
- Stall  out  1  control must hold current state
- IR  out  DATA_W  instruction register
- OPcode  out  5  IR[DATA_W-1:DATA_W-5]
- MDR  out  DATA_W  memory data register
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  ADDR_W  bus address
- mem_wdata  out  DATA_W  bus write data
- mem_rdata  in  DATA_W  bus read data, valid with mem_ack
- mem_ack  in  1  bus completion, one-cycle pulse
- err_timeout  out  1  sticky: an access timed out
- err_illegal  out  1  sticky: MemRead and MemWrite high together

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; IR, MDR, mem_addr, mem_wdata, count = 0; mem_req, mem_we, err_timeout, err_illegal = 0.
- A reset mid-access drops mem_req immediately. A late mem_ack after reset is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, MemRead^MemWrite=1:
  - latch mem_addr = IorD ? alu_addr : pc_addr
  - latch mem_we = MemWrite, mem_wdata = wdata, dest = IRenable
  - set mem_req=1, count=0, go BUSY
- IDLE, MemRead&MemWrite=1: set err_illegal, no bus access, stay IDLE, Stall=0.
- BUSY: mem_req held, and address/data/we held stable. Each cycle:
  - mem_ack=1: on reads, load mem_rdata into IR (dest=1) or MDR (dest=0); drop mem_req and mem_we; go DONE.
  - else if count==TIMEOUT-1: drop mem_req; on reads load ERR_DATA into the destination; set err_timeout; go DONE.
  - else count++.
  - A write leaves IR and MDR unchanged.
- DONE: one cycle; the command inputs are ignored; go IDLE.
- Stall = (IDLE & (MemRead^MemWrite)) | BUSY. Stall is combinational, and it is 0 in DONE so control advances exactly once.
- Minimum latency: command in cycle N, ack in N+1, IR/MDR valid and Stall=0 in N+2.
- mem_ack arriving while in IDLE or DONE is ignored.
- IR and MDR change only on read completion or timeout. OPcode is stable across all non-fetch states.
- Error flags clear only on reset.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams IDLE/BUSY/DONE
  - OPcode field position constants
  - DATA_W/ADDR_W defaults
  - ERR_DATA constant
- Natural sub-module: mem_timeout_ctr. Inputs: clear and enable. Output: expired at TIMEOUT-1. This keeps the counter independently testable.
- The rest is one FSM plus datapath registers.

Test Plan:
- Fetch read: IorD=0, IRenable=1, MemRead=1, pc_addr=16'h0010; ack after 2 cycles with rdata=16'h5A01 → mem_addr=0010, mem_we=0, Stall high 3 cycles then low 1 cycle, IR=5A01, OPcode=5'b01011, MDR unchanged.
- Load: IorD=1, IRenable=0, alu_addr=16'h0200, immediate ack with rdata=16'h1234 → MDR=1234 at N+2, IR unchanged, single mem_req period.
- Store: MemWrite=1, wdata=16'hBEEF, alu_addr=16'h0300, ack after 1 cycle → mem_we=1 and mem_wdata=BEEF stable for the whole request, IR/MDR unchanged, no second request while the command is held through DONE.
- Timeout: TIMEOUT=4, read with no ack → mem_req drops after 4 BUSY cycles, err_timeout=1, destination=FFFF, Stall deasserts one cycle later.
- Illegal/reset: MemRead=MemWrite=1 → err_illegal=1, mem_req stays 0. Separately, assert Reset low mid-BUSY → mem_req=0 immediately, IR=0; a subsequent ack is ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory interface stage: state encoding,
// OPcode field placement, default widths and the timeout fill value.
package cpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // OPcode occupies the top OPC_W bits of the instruction register
  localparam int OPC_W = 5;

  localparam logic [15:0] ERR_DATA_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-wait counter: counts BUSY cycles and flags the last permitted one.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic Reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins; saturate at LAST so the count never wraps
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_iface.sv
// Memory interface stage: turns MemRead/MemWrite from the control FSM into
// one req/ack bus transaction, stalls control until it completes, and holds
// IR/MDR. DONE is a one-cycle window with Stall low so a command still held
// by control is not re-issued.
module mem_iface
  import cpu_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                TIMEOUT  = 15,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRenable,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              Stall,
  output logic [DATA_W-1:0] IR,
  output logic [OPC_W-1:0]  OPcode,
  output logic [DATA_W-1:0] MDR,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout,
  output logic              err_illegal
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic                dest_q, dest_d;
  logic                err_to_q, err_to_d;
  logic                err_il_q, err_il_d;
  logic                expired;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .CLK       (CLK),
    .Reset     (Reset),
    .clear_i   (state_q != BUSY),
    .enable_i  (state_q == BUSY),
    .expired_o (expired)
  );

  // Next-state and datapath updates; every register holds by default
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    mdr_d    = mdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    req_d    = req_q;
    we_d     = we_q;
    dest_d   = dest_q;
    err_to_d = err_to_q;
    err_il_d = err_il_q;
    case (state_q)
      IDLE: begin
        if (MemRead && MemWrite) begin
          err_il_d = 1'b1;
        end else if (MemRead ^ MemWrite) begin
          addr_d  = IorD ? alu_addr : pc_addr;
          we_d    = MemWrite;
          wdata_d = wdata;
          dest_d  = IRenable;
          req_d   = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (!we_q) begin
            if (dest_q) ir_d = mem_rdata;
            else        mdr_d = mem_rdata;
          end
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end else if (expired) begin
          if (!we_q) begin
            if (dest_q) ir_d = ERR_DATA;
            else        mdr_d = ERR_DATA;
          end
          req_d    = 1'b0;
          we_d     = 1'b0;
          err_to_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      mdr_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      dest_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_il_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      we_q     <= we_d;
      dest_q   <= dest_d;
      err_to_q <= err_to_d;
      err_il_q <= err_il_d;
    end
  end

  assign Stall       = ((state_q == IDLE) && (MemRead ^ MemWrite)) || (state_q == BUSY);
  assign IR          = ir_q;
  assign OPcode      = ir_q[DATA_W-1 -: OPC_W];
  assign MDR         = mdr_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign err_timeout = err_to_q;
  assign err_illegal = err_il_q;

endmodule

// File: tb/tb_mem_iface.sv
module tb_mem_iface;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, IorD = 1'b0, IRenable = 1'b0;
  logic [15:0] pc_addr = '0, alu_addr = '0, wdata = '0, mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        Stall, mem_req, mem_we, err_timeout, err_illegal;
  logic [15:0] IR, MDR, mem_addr, mem_wdata;
  logic [4:0]  OPcode;

  int tests = 0;
  int fails = 0;

  mem_iface #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(4), .ERR_DATA(16'hFFFF)) dut (
    .CLK(CLK), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .IorD(IorD), .IRenable(IRenable), .pc_addr(pc_addr), .alu_addr(alu_addr),
    .wdata(wdata), .Stall(Stall), .IR(IR), .OPcode(OPcode), .MDR(MDR),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_timeout(err_timeout),
    .err_illegal(err_illegal)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    #1;
    tests++; if ({mem_req, mem_we, Stall, err_timeout, err_illegal} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, Stall, err_timeout, err_illegal}); end
    tests++; if ({IR, MDR, mem_addr, mem_wdata} !== 64'h0) begin fails++; $display("FAIL reset_regs got=%h exp=0", {IR, MDR, mem_addr, mem_wdata}); end
    Reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    MemRead = 1'b1; IorD = 1'b0; IRenable = 1'b1; pc_addr = 16'h0010; alu_addr = 16'h7777;
    #1;
    tests++; if (Stall !== 1'b1 || mem_req !== 1'b0) begin fails++; $display("FAIL fetch_n stall=%b req=%b exp 1/0", Stall, mem_req); end
    tick();
    #1;
    tests++; if (Stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin fails++; $display("FAIL fetch_busy1 stall=%b req=%b addr=%h we=%b exp 1/1/0010/0", Stall, mem_req, mem_addr, mem_we); end
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h5A01;
    #1;
    tests++; if (Stall !== 1'b1 || mem_req !== 1'b1) begin fails++; $display("FAIL fetch_busy2 stall=%b req=%b exp 1/1", Stall, mem_req); end
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    #1;
    tests++; if (Stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL fetch_done stall=%b req=%b exp 0/0", Stall, mem_req); end
    tests++; if (IR !== 16'h5A01 || OPcode !== 5'b01011 || MDR !== 16'h0000) begin fails++; $display("FAIL fetch_ir ir=%h op=%b mdr=%h exp 5a01/01011/0000", IR, OPcode, MDR); end
    MemRead = 1'b0;
    tick();
  endtask

  task automatic test_load();
    MemRead = 1'b1; IorD = 1'b1; IRenable = 1'b0; alu_addr = 16'h0200; pc_addr = 16'h0044;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200) begin fails++; $display("FAIL load_req req=%b addr=%h exp 1/0200", mem_req, mem_addr); end
    tick();
    mem_ack = 1'b0;
    #1;
    tests++; if (MDR !== 16'h1234 || IR !== 16'h5A01 || Stall !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL load_done mdr=%h ir=%h stall=%b req=%b exp 1234/5a01/0/0", MDR, IR, Stall, mem_req); end
    MemRead = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL load_single req=%b exp 0", mem_req); end
    tick();
    mem_ack = 1'b0;
    #1;
    tests++; if (MDR !== 16'h1234 || IR !== 16'h5A01 || mem_req !== 1'b0) begin fails++; $display("FAIL idle_ack mdr=%h ir=%h req=%b exp 1234/5a01/0", MDR, IR, mem_req); end
  endtask

  task automatic test_store();
    MemWrite = 1'b1; IorD = 1'b1; alu_addr = 16'h0300; wdata = 16'hBEEF;
    tick();
    wdata = 16'h0000;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h0300) begin fails++; $display("FAIL store_busy1 req=%b we=%b wd=%h addr=%h exp 1/1/beef/0300", mem_req, mem_we, mem_wdata, mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    #1;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h0300) begin fails++; $display("FAIL store_busy2 req=%b we=%b wd=%h addr=%h exp 1/1/beef/0300", mem_req, mem_we, mem_wdata, mem_addr); end
    tick();
    mem_ack = 1'b0;
    #1;
    tests++; if (Stall !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || IR !== 16'h5A01 || MDR !== 16'h1234) begin fails++; $display("FAIL store_done stall=%b req=%b we=%b ir=%h mdr=%h exp 0/0/0/5a01/1234", Stall, mem_req, mem_we, IR, MDR); end
    tick();
    MemWrite = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL store_no_reissue req=%b exp 0", mem_req); end
    tick();
  endtask

  task automatic test_timeout();
    MemRead = 1'b1; IorD = 1'b0; IRenable = 1'b0; pc_addr = 16'h0500;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      tests++; if (mem_req !== 1'b1 || Stall !== 1'b1) begin fails++; $display("FAIL timeout_busy%0d req=%b stall=%b exp 1/1", i, mem_req, Stall); end
    end
    tick();
    #1;
    tests++; if (mem_req !== 1'b0 || Stall !== 1'b0 || err_timeout !== 1'b1) begin fails++; $display("FAIL timeout_done req=%b stall=%b err=%b exp 0/0/1", mem_req, Stall, err_timeout); end
    tests++; if (MDR !== 16'hFFFF || IR !== 16'h5A01) begin fails++; $display("FAIL timeout_data mdr=%h ir=%h exp ffff/5a01", MDR, IR); end
    MemRead = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    tests++; if (Stall !== 1'b0) begin fails++; $display("FAIL illegal_stall got=%b exp 0", Stall); end
    tick();
    #1;
    tests++; if (err_illegal !== 1'b1 || mem_req !== 1'b0 || err_timeout !== 1'b1) begin fails++; $display("FAIL illegal_flag ill=%b req=%b to=%b exp 1/0/1", err_illegal, mem_req, err_timeout); end
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    #1;
    tests++; if (err_illegal !== 1'b1) begin fails++; $display("FAIL illegal_sticky got=%b exp 1", err_illegal); end
  endtask

  task automatic test_reset_mid_busy();
    MemRead = 1'b1; IorD = 1'b0; IRenable = 1'b1; pc_addr = 16'h0040;
    tick();
    #1;
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rst_pre req=%b exp 1", mem_req); end
    Reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || IR !== 16'h0000 || MDR !== 16'h0000 || err_timeout !== 1'b0 || err_illegal !== 1'b0) begin fails++; $display("FAIL rst_async req=%b ir=%h mdr=%h to=%b ill=%b exp 0/0/0/0/0", mem_req, IR, MDR, err_timeout, err_illegal); end
    MemRead = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hAAAA;
    tick();
    mem_ack = 1'b0;
    #1;
    tests++; if (IR !== 16'h0000 || MDR !== 16'h0000 || mem_req !== 1'b0 || Stall !== 1'b0) begin fails++; $display("FAIL rst_late_ack ir=%h mdr=%h req=%b stall=%b exp 0/0/0/0", IR, MDR, mem_req, Stall); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_timeout();
    test_illegal();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
